undo_restore_dispatcher: RTL

Serializer-side responder for the undo log's restore protocol, one per tile next to the undo log. Queues abort requests for CQ slots and hands each one to a free undo-log thread that is requesting work. Collects each thread's restore-done handshake and forwards a single ordered abort-done stream back to the conflict serializer. Tracks per-thread occupancy and flags protocol violations.

---
 rtl/undo_restore_dispatcher.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/undo_restore_dispatcher.sv
// Abort queue plus dispatch/collect logic between the conflict serializer and the undo-log restore threads.
// Latency: grant is combinational from arvalid; abort_done is registered, one cycle after a restore-done accept.
// Backpressure: abort_ready drops while the queue is full; restore_done_ready waits for the completion register to drain.

// Generic single-clock FIFO with an unregistered head read.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push is ignored while full (no bypass); pop is ignored while empty.
module sync_fifo #(
  parameter int W         = 8,
  parameter int LOG_DEPTH = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 2 ** LOG_DEPTH;

  logic [W-1:0]       mem [DEPTH];
  logic [LOG_DEPTH:0] wptr;
  logic [LOG_DEPTH:0] rptr;
  logic               do_push;
  logic               do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rptr[LOG_DEPTH-1:0]];
  assign empty    = (wptr == rptr);
  // pointers carry one wrap bit: full when only that bit differs
  assign full     = (wptr == {~rptr[LOG_DEPTH], rptr[LOG_DEPTH-1:0]});

  // data array write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[LOG_DEPTH-1:0]] <= push_dat;
  end

  // pointer advance
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end
endmodule

module undo_restore_dispatcher #(
  parameter int                     UNDO_LOG_THREADS           = 4,
  parameter int                     LOG_ABORT_FIFO_DEPTH       = 3,
  parameter int                     CQ_SLOT_W                  = 8,
  parameter int                     THREAD_ID_W                = 4,
  parameter int                     TASK_TYPE_W                = 4,
  parameter logic [TASK_TYPE_W-1:0] TASK_TYPE_UNDO_LOG_RESTORE = 4'd2
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic                                    abort_valid,
  output logic                                    abort_ready,
  input  logic [CQ_SLOT_W-1:0]                    abort_cq_slot,
  input  logic [THREAD_ID_W-1:0]                  abort_thread_id,
  input  logic [UNDO_LOG_THREADS-1:0]             restore_arvalid,
  input  logic [UNDO_LOG_THREADS*TASK_TYPE_W-1:0] restore_araddr,
  output logic [UNDO_LOG_THREADS-1:0]             restore_rvalid,
  output logic [CQ_SLOT_W-1:0]                    restore_cq_slot,
  output logic [THREAD_ID_W-1:0]                  restore_thread_id,
  input  logic [UNDO_LOG_THREADS-1:0]             restore_done_valid,
  output logic [UNDO_LOG_THREADS-1:0]             restore_done_ready,
  input  logic [UNDO_LOG_THREADS*CQ_SLOT_W-1:0]   restore_done_cq_slot,
  input  logic [UNDO_LOG_THREADS*THREAD_ID_W-1:0] restore_done_thread_id,
  output logic                                    abort_done_valid,
  input  logic                                    abort_done_ready,
  output logic [CQ_SLOT_W-1:0]                    abort_done_cq_slot,
  output logic [THREAD_ID_W-1:0]                  abort_done_thread_id,
  output logic [UNDO_LOG_THREADS-1:0]             in_flight,
  output logic                                    protocol_error
);
  localparam int T  = UNDO_LOG_THREADS;
  localparam int TW = $clog2(UNDO_LOG_THREADS);
  localparam int EW = CQ_SLOT_W + THREAD_ID_W;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [EW-1:0] fifo_head;

  logic [T-1:0]  ar_match;
  logic [T-1:0]  req;
  logic [T-1:0]  disp_grant;
  logic          disp_found;

  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] rr_idx;
  logic [TW-1:0] done_idx;
  logic [T-1:0]  done_grant;
  logic          done_found;
  logic          done_accept;

  logic [CQ_SLOT_W-1:0]   done_slot;
  logic [THREAD_ID_W-1:0] done_tid;
  logic [10:0]            full_wait_cnt;
  logic                   bad_done;
  logic                   bad_req;

  // abort_ready is forced low while reset is held so nothing is taken in during reset
  assign abort_ready = rstn && !fifo_full;
  assign fifo_push   = abort_valid && abort_ready;

  sync_fifo #(
    .W        (EW),
    .LOG_DEPTH(LOG_ABORT_FIFO_DEPTH)
  ) u_abort_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (fifo_push),
    .push_dat({abort_cq_slot, abort_thread_id}),
    .pop     (fifo_pop),
    .head_dat(fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign restore_cq_slot   = fifo_head[EW-1:THREAD_ID_W];
  assign restore_thread_id = fifo_head[THREAD_ID_W-1:0];

  // dispatch: fixed priority to the lowest idle thread presenting a valid restore request
  always_comb begin
    ar_match   = '0;
    req        = '0;
    disp_grant = '0;
    disp_found = 1'b0;
    for (int t = 0; t < T; t++) begin
      ar_match[t] = restore_arvalid[t] &&
                    (restore_araddr[t*TASK_TYPE_W +: TASK_TYPE_W] == TASK_TYPE_UNDO_LOG_RESTORE);
      req[t]      = ar_match[t] && !in_flight[t];
      if (req[t] && !disp_found) begin
        disp_grant[t] = 1'b1;
        disp_found    = 1'b1;
      end
    end
  end

  // an empty queue grants nothing, so the thread's request simply stays pending
  assign restore_rvalid = fifo_empty ? '0 : disp_grant;
  assign fifo_pop       = |restore_rvalid;

  // done arbitration: round-robin search starting at rr_ptr
  always_comb begin
    done_grant = '0;
    done_found = 1'b0;
    done_idx   = '0;
    rr_idx     = '0;
    for (int i = 0; i < T; i++) begin
      rr_idx = rr_ptr + TW'(i);
      if (restore_done_valid[rr_idx] && !done_found) begin
        done_grant[rr_idx] = 1'b1;
        done_idx           = rr_idx;
        done_found         = 1'b1;
      end
    end
  end

  // the completion register takes a new entry when empty or draining this cycle
  assign done_accept        = done_found && (!abort_done_valid || abort_done_ready);
  assign restore_done_ready = (rstn && done_accept) ? done_grant : '0;
  assign done_slot          = restore_done_cq_slot[done_idx*CQ_SLOT_W +: CQ_SLOT_W];
  assign done_tid           = restore_done_thread_id[done_idx*THREAD_ID_W +: THREAD_ID_W];

  // completion register toward the serializer; held stable while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      abort_done_valid     <= 1'b0;
      abort_done_cq_slot   <= '0;
      abort_done_thread_id <= '0;
    end else if (done_accept) begin
      abort_done_valid     <= 1'b1;
      abort_done_cq_slot   <= done_slot;
      abort_done_thread_id <= done_tid;
    end else if (abort_done_ready) begin
      abort_done_valid     <= 1'b0;
    end
  end

  // round-robin pointer moves just past the thread that was accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (done_accept) begin
      rr_ptr <= done_idx + 1'b1;
    end
  end

  // per-thread occupancy: set on grant, cleared on done accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_flight <= '0;
    end else begin
      in_flight <= (in_flight & ~(done_accept ? done_grant : '0)) | restore_rvalid;
    end
  end

  assign bad_done = |(restore_done_valid & ~in_flight);
  assign bad_req  = |(ar_match & in_flight);

  // sticky protocol checker; the stall counter saturates once it reaches its limit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      protocol_error <= 1'b0;
      full_wait_cnt  <= '0;
    end else begin
      if (bad_done || bad_req) protocol_error <= 1'b1;
      if (abort_valid && fifo_full) begin
        if (full_wait_cnt == 11'd1024) protocol_error <= 1'b1;
        else                           full_wait_cnt  <= full_wait_cnt + 1'b1;
      end else begin
        full_wait_cnt <= '0;
      end
    end
  end
endmodule
